// File: rtl/debounce_pkg.sv
// Shared defaults and sizing helpers for the debounce bank.
package debounce_pkg;

  localparam int DEF_CH          = 4;
  localparam int DEF_STABLE      = 1000;
  localparam int DEF_CNT_W       = 10;
  localparam int DEF_SYNC_STAGES = 2;

  // Smallest counter width w (>=1) such that 2^w >= stable.
  function automatic int min_cnt_w(input int stable);
    int w;
    w = 1;
    while ((32'sd1 <<< w) < stable) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One input channel: synchroniser, stability counter, debounced level and edge pulses.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   STABLE      = DEF_STABLE,
  parameter int   CNT_W       = DEF_CNT_W,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  input  logic bypass_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Next-state: the counter only runs while the synchronised level disagrees with out.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_i};
    cnt_d  = cnt_q;
    out_d  = out_q;
    if (bypass_i) begin
      out_d = sync_s;
      cnt_d = '0;
    end else if (sync_s == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      out_d = sync_s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;
  end

  // Channel state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{INIT}};
      cnt_q  <= '0;
      out_q  <= INIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced input channels with a combined change indicator.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   CH          = DEF_CH,
  parameter int   STABLE      = DEF_STABLE,
  parameter int   CNT_W       = DEF_CNT_W,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic INIT        = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] in,
  input  logic          bypass,
  output logic [CH-1:0] out,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          any_change
);

  // Reject parameter sets the channel logic cannot honour.
  if (CNT_W < min_cnt_w(STABLE)) begin : g_cnt_w_chk
    $error("debounce_bank: CNT_W too small for STABLE");
  end
  if (STABLE < 1) begin : g_stable_chk
    $error("debounce_bank: STABLE must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("debounce_bank: SYNC_STAGES must be >= 2");
  end
  if (CH < 1) begin : g_ch_chk
    $error("debounce_bank: CH must be >= 1");
  end

  for (genvar i = 0; i < CH; i++) begin : g_chan
    debounce_chan #(
      .STABLE      (STABLE),
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .INIT        (INIT)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .in_i     (in[i]),
      .bypass_i (bypass),
      .out_o    (out[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i])
    );
  end

  assign any_change = |(rise | fall);

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench: three banks (STABLE=4, 1, 1000) share stimulus and are checked against a run-length model.
module tb_debounce_bank;

  localparam int CH   = 4;
  localparam int SYNC = 2;

  typedef struct packed {
    logic [2:0][3:0] out;
    logic [2:0][3:0] rise;
    logic [2:0][3:0] fall;
    logic [2:0]      any;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in;
  logic       bypass;

  logic [3:0] out_a, rise_a, fall_a, out_b, rise_b, fall_b, out_c, rise_c, fall_c;
  logic       any_a, any_b, any_c;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  int         stab[3] = '{4, 1, 1000};
  logic [3:0] m_out[3];
  int         m_run[3][4];
  logic [3:0] m_inq[$];

  debounce_bank #(.CH(CH), .STABLE(4), .CNT_W(2), .SYNC_STAGES(SYNC), .INIT(1'b0)) u_a (
    .clk(clk), .rst(rst), .in(in), .bypass(bypass),
    .out(out_a), .rise(rise_a), .fall(fall_a), .any_change(any_a));
  debounce_bank #(.CH(CH), .STABLE(1), .CNT_W(1), .SYNC_STAGES(SYNC), .INIT(1'b0)) u_b (
    .clk(clk), .rst(rst), .in(in), .bypass(bypass),
    .out(out_b), .rise(rise_b), .fall(fall_b), .any_change(any_b));
  debounce_bank #(.CH(CH), .STABLE(1000), .CNT_W(10), .SYNC_STAGES(SYNC), .INIT(1'b0)) u_c (
    .clk(clk), .rst(rst), .in(in), .bypass(bypass),
    .out(out_c), .rise(rise_c), .fall(fall_c), .any_change(any_c));

  always #5 clk = ~clk;

  task automatic check4(input string nm, input int k, input logic [3:0] got, input logic [3:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", nm, k, cyc, got, want);
    end
  endtask

  // Reference: out flips once the synchronised level has disagreed for STABLE edges in a row.
  task automatic model_step();
    exp_t       e;
    logic [3:0] s_v, rs, fl;
    if (!rst) begin
      m_inq.delete();
      for (int j = 0; j < SYNC; j++) m_inq.push_back(4'b0000);
      for (int k = 0; k < 3; k++) begin
        m_out[k] = 4'b0000;
        for (int i = 0; i < 4; i++) m_run[k][i] = 0;
        e.out[k] = 4'b0000; e.rise[k] = 4'b0000; e.fall[k] = 4'b0000; e.any[k] = 1'b0;
      end
    end else begin
      s_v = m_inq.pop_front();
      m_inq.push_back(in);
      for (int k = 0; k < 3; k++) begin
        rs = 4'b0000;
        fl = 4'b0000;
        for (int i = 0; i < 4; i++) begin
          if (bypass) begin
            if (s_v[i] != m_out[k][i]) begin
              if (s_v[i]) rs[i] = 1'b1; else fl[i] = 1'b1;
              m_out[k][i] = s_v[i];
            end
            m_run[k][i] = 0;
          end else if (s_v[i] == m_out[k][i]) begin
            m_run[k][i] = 0;
          end else begin
            m_run[k][i] = m_run[k][i] + 1;
            if (m_run[k][i] == stab[k]) begin
              if (s_v[i]) rs[i] = 1'b1; else fl[i] = 1'b1;
              m_out[k][i] = s_v[i];
              m_run[k][i] = 0;
            end
          end
        end
        e.out[k] = m_out[k]; e.rise[k] = rs; e.fall[k] = fl; e.any[k] = |(rs | fl);
      end
    end
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: every edge produces an output set; compare it against the queued expectation.
  initial begin
    exp_t       e;
    logic [3:0] a_out[3], a_rise[3], a_fall[3];
    logic       a_any[3];
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a_out  = '{out_a, out_b, out_c};
        a_rise = '{rise_a, rise_b, rise_c};
        a_fall = '{fall_a, fall_b, fall_c};
        a_any  = '{any_a, any_b, any_c};
        for (int k = 0; k < 3; k++) begin
          check4("out", k, a_out[k], e.out[k]);
          check4("rise", k, a_rise[k], e.rise[k]);
          check4("fall", k, a_fall[k], e.fall[k]);
          check4("any_change", k, {3'b000, a_any[k]}, {3'b000, e.any[k]});
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [3:0] m;
    rst = 1'b0; in = 4'hF; bypass = 1'b0;
    hold(3);
    check4("reset_out", 0, out_a, 4'b0000);
    check4("reset_any", 0, {3'b000, any_a}, 4'b0000);
    rst = 1'b1; in = 4'b0000;
    hold(8);
    in = 4'b0001;
    hold(12);
    in[1] = 1'b1; hold(3);
    in[1] = 1'b0; hold(1);
    in[1] = 1'b1; hold(12);
    in = 4'hF;     hold(12);
    in = 4'b0011;  hold(12);
    bypass = 1'b1;
    for (int t = 0; t < 6; t++) begin
      in[0] = ~in[0];
      hold(3);
    end
    in[0] = ~in[0]; hold(1);
    bypass = 1'b0; hold(3);
    in[0] = ~in[0]; hold(12);
    for (int t = 0; t < 400; t++) begin
      m = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      in = in ^ m;
      bypass = ($urandom_range(0, 9) == 0);
      hold($urandom_range(1, 7));
    end
    bypass = 1'b0;
    for (int t = 0; t < 3; t++) begin
      in = in ^ 4'($urandom_range(1, 15));
      hold(1010);
    end
    in = 4'hF; hold(1010);
    check4("pre_reset_out", 0, out_a, 4'hF);
    #2;
    rst = 1'b0;
    #1;
    check4("async_reset_out", 0, out_a, 4'b0000);
    check4("async_reset_out", 1, out_b, 4'b0000);
    check4("async_reset_out", 2, out_c, 4'b0000);
    hold(3);
    rst = 1'b1;
    hold(20);
    hold(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
